pll_reconfig: RTL and testbench
===============================

# pll_reconfig

Runtime DRP reconfiguration controller for one PLLE2_ADV, generalising the fixed-ratio clock generation in `clocks` to software-selectable multiply/divide ratios on up to six outputs. It sits in the `clk_125mhz` domain beside the PLL instance and drives the PLL's DRP port and RST pin. It accepts a ratio set through a valid/ready handshake, checks it, and read-modify-writes the divider registers while holding the PLL in reset. It then waits for lock and reports status.

## Interface
- NUM_OUT, 2, number of CLKOUTn dividers programmed (1..6, CLKOUT0 upward)
- DRDY_TIMEOUT, 255, max cycles to wait for drp_drdy per access
- LOCK_TIMEOUT, 65535, max cycles to wait for lock after PLL reset release
- clk  in  1  DRP clock (the 125 MHz input clock)
- rst_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low
- cfg_valid  in  1  request valid
- cfg_ready  out  1  high only in IDLE
- cfg_mult  in  7  CLKFBOUT_MULT, legal 2..64
- cfg_divclk  in  6  DIVCLK_DIVIDE, legal 1..56
- cfg_clkout_div  in  7*NUM_OUT  CLKOUTn_DIVIDE at bits [7n+6:7n], legal 1..126
- busy  out  1  request in progress
- done  out  1  one-cycle pulse at completion
- err  out  2  0 ok, 1 invalid config, 2 DRP timeout, 3 lock timeout; valid with done, held until next done
- pll_rst  out  1  to PLL RST
- drp_den, drp_dwe  out  1  DRP enable / write enable
- drp_daddr  out  7  DRP address
- drp_di  out  16  DRP write data
- drp_do  in  16  DRP read data
- drp_drdy  in  1  DRP ready
- pll_locked  in  1  PLL LOCKED (asynchronous; 2-FF synchronised internally)
- locked  out  1  synchronised lock AND state IDLE

## Operation
- States: IDLE, CHECK, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, DONE.
- IDLE: cfg_ready=1. On cfg_valid, latch all cfg_* and go to CHECK.
- CHECK: any field out of range gives err=1, then DONE. No DRP access and pll_rst untouched. Otherwise assert pll_rst, zero the register index, and go to RD.
- Register sequence (index k = 0..2*NUM_OUT+2): CLKOUTn Reg1 0x08+2n, Reg2 0x09+2n for n=0..NUM_OUT-1; then CLKFBOUT 0x14, 0x15; then DIVCLK 0x16.
- Divider encoding for value D:
  - high = D>>1, low = D-high, edge = D[0], nocount = 0.
  - D==1 uses high=1, low=1, edge=0, nocount=1.
- Reg1 (0x08..0x14): new = (old & 0xF000) | high<<6 | low.
- Reg2 (0x09..0x15): new = (old & 0xFF3F) | edge<<7 | nocount<<6.
- DIVCLK 0x16: new = (old & 0xC000) | edge<<13 | nocount<<12 | high<<6 | low.
- Lock/filter registers are not modified.
- RD: one-cycle den with dwe=0 and daddr set, then RD_WAIT. On drdy, capture drp_do and go to WR.
- WR: one-cycle den+dwe with di=new, then WR_WAIT. On drdy, either increment k and go to RD, or after the last register deassert pll_rst and go to LOCK_WAIT.
- If drdy does not arrive within DRDY_TIMEOUT cycles in RD_WAIT or WR_WAIT: err=2, pll_rst deasserted, then DONE.
- LOCK_WAIT: synchronised lock high gives err=0 and DONE. LOCK_TIMEOUT cycles without lock gives err=3 and DONE.
- DONE: done=1 for one cycle, then IDLE.
- cfg_* changes while busy are ignored. drdy outside a wait state is ignored.

## Timing
- Reset values: cfg_ready=1, busy=0, done=0, err=0, pll_rst=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, locked=0, FSM=IDLE, synchroniser flops=0.
- Reset mid-sequence: FSM returns to IDLE at once and pll_rst drops. PLL register contents are then undefined; software must issue a new request.
- Accept at cycle N (valid && ready), CHECK at N+1, pll_rst high and first den at N+2.
- Each register costs 4 cycles plus DRP latency.
- drdy in the cycle after den is accepted (0 extra wait).
- Timeout counters reset on entry to each wait state. A timeout fires on the cycle the counter equals its limit with drdy/lock still low.
- locked is deasserted from accept until the return to IDLE.
- Synchroniser latency is 2 cycles. pll_rst is held for at least 2*NUM_OUT+3 accesses, so synchronised lock is already low when LOCK_WAIT is entered.

## Test plan
- Reset mid-WR_WAIT (rst_n low 3 cycles) -> den=0 and pll_rst=0 at once, cfg_ready=1 after release, done never pulses.
- NUM_OUT=1, mult=34, divclk=5, div0=17, DRP model returns 0xFFFF on reads. Required writes:
  - 0x08 ← 0xF209
  - 0x09 ← 0xFFBF
  - 0x14 ← 0xF451
  - 0x15 ← 0xFF3F
  - 0x16 ← 0xE083
  - then lock high after 100 cycles -> done with err=0, locked=1.
- div0=1, reads 0x0000 -> 0x08 ← 0x0041, 0x09 ← 0x0040.
- div0=0 or mult=65 -> done 2 cycles after accept with err=1, no den, pll_rst never high.
- DRP model never asserts drdy -> err=2 after DRDY_TIMEOUT cycles on the first read, pll_rst low, FSM back in IDLE.
- Lock held low -> err=3 after LOCK_TIMEOUT cycles. cfg_valid pulsed while busy is not accepted.

Source files
------------

// File: rtl/pll_reconfig.sv
// -----------------------------------------------------------------------------
// pll_reconfig
//   Runtime DRP reconfiguration controller for one PLLE2_ADV. A ratio set is
//   accepted through a valid/ready handshake and then range-checked. While the
//   PLL is held in reset, the controller read-modify-writes the CLKOUTn,
//   CLKFBOUT and DIVCLK divider registers. It then waits for lock and reports
//   the outcome with a one-cycle done pulse and a held error code.
//
// Ports
//   clk, rst_n          DRP clock, asynchronous active-low reset
//   cfg_valid/ready     request handshake (ready only in IDLE)
//   cfg_mult            CLKFBOUT_MULT      (2..64)
//   cfg_divclk          DIVCLK_DIVIDE      (1..56)
//   cfg_clkout_div      CLKOUTn_DIVIDE at [7n+6:7n] (1..126)
//   busy, done, err     status: err 0 ok, 1 bad config, 2 DRP timeout,
//                       3 lock timeout; err is valid with done and held after
//   pll_rst             PLL RST pin
//   drp_*               DRP master port
//   pll_locked          raw PLL LOCKED (asynchronous)
//   locked              synchronised lock, only reported while IDLE
// -----------------------------------------------------------------------------
module pll_reconfig #(
    parameter int NUM_OUT      = 2,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [6:0]           cfg_mult,
    input  logic [5:0]           cfg_divclk,
    input  logic [7*NUM_OUT-1:0] cfg_clkout_div,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic                 pll_rst,
    output logic                 drp_den,
    output logic                 drp_dwe,
    output logic [6:0]           drp_daddr,
    output logic [15:0]          drp_di,
    input  logic [15:0]          drp_do,
    input  logic                 drp_drdy,
    input  logic                 pll_locked,
    output logic                 locked
);

    localparam int NUM_REG = 2 * NUM_OUT + 3;
    localparam int TMAX    = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0] DRDY_LIMIT = TW'(DRDY_TIMEOUT);
    localparam logic [TW-1:0] LOCK_LIMIT = TW'(LOCK_TIMEOUT);
    localparam logic [3:0]    LAST_REG   = 4'(NUM_REG - 1);
    localparam logic [3:0]    FB_REG     = 4'(2 * NUM_OUT);

    typedef enum logic [2:0] {
        IDLE, CHECK, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           mult_q, mult_d;
    logic [5:0]           divclk_q, divclk_d;
    logic [7*NUM_OUT-1:0] div_q, div_d;
    logic [3:0]           reg_idx_q, reg_idx_d;
    logic [15:0]          rd_data_q, rd_data_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 pll_rst_q, pll_rst_d;
    logic [1:0]           err_q, err_d;
    logic                 lock_meta, lock_sync;

    logic                 cfg_ok;
    logic [6:0]           cur_val;
    logic [6:0]           cur_addr;

    // Divider word merge. D==1 is the bypass case: the counter is told to
    // ignore high/low via nocount rather than by encoding a 1-cycle period.
    function automatic logic [15:0] encode_word(input logic [6:0]  addr,
                                                input logic [6:0]  d,
                                                input logic [15:0] old);
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_b;
        logic       nocount;
        high    = d[6:1];
        low     = 6'(d - {1'b0, d[6:1]});
        edge_b  = d[0];
        nocount = 1'b0;
        if (d == 7'd1) begin
            high    = 6'd1;
            low     = 6'd1;
            edge_b  = 1'b0;
            nocount = 1'b1;
        end
        if (addr == 7'h16)
            return (old & 16'hC000) | {2'b00, edge_b, nocount, high, low};
        else if (!addr[0])
            return (old & 16'hF000) | {4'b0000, high, low};
        else
            return (old & 16'hFF3F) | {8'h00, edge_b, nocount, 6'b000000};
    endfunction

    // Legality of the latched request.
    always_comb begin
        cfg_ok = (mult_q >= 7'd2) && (mult_q <= 7'd64) &&
                 (divclk_q >= 6'd1) && (divclk_q <= 6'd56);
        for (int n = 0; n < NUM_OUT; n++) begin
            if (div_q[7*n +: 7] == 7'd0 || div_q[7*n +: 7] == 7'd127)
                cfg_ok = 1'b0;
        end
    end

    // Register index -> DRP address and divider value. Indices below FB_REG
    // walk the CLKOUTn Reg1/Reg2 pairs; the last three are CLKFBOUT and DIVCLK.
    always_comb begin
        cur_val  = 7'(divclk_q);
        cur_addr = 7'h16;
        if (reg_idx_q < FB_REG) begin
            cur_addr = 7'h08 + 7'(reg_idx_q);
            cur_val  = div_q[6:0];
            for (int n = 1; n < NUM_OUT; n++) begin
                if (reg_idx_q[3:1] == 3'(n))
                    cur_val = div_q[7*n +: 7];
            end
        end else if (reg_idx_q != LAST_REG) begin
            cur_addr = 7'h14 + 7'(reg_idx_q - FB_REG);
            cur_val  = mult_q;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case below leaves it unassigned (which would infer a latch).
        state_d   = state_q;
        mult_d    = mult_q;
        divclk_d  = divclk_q;
        div_d     = div_q;
        reg_idx_d = reg_idx_q;
        rd_data_d = rd_data_q;
        pll_rst_d = pll_rst_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    mult_d   = cfg_mult;
                    divclk_d = cfg_divclk;
                    div_d    = cfg_clkout_div;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!cfg_ok) begin
                    err_d   = 2'd1;
                    state_d = DONE;
                end else begin
                    pll_rst_d = 1'b1;
                    reg_idx_d = '0;
                    state_d   = RD;
                end
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                if (drp_drdy) begin
                    rd_data_d = drp_do;
                    state_d   = WR;
                end else if (timer_q == DRDY_LIMIT) begin
                    err_d     = 2'd2;
                    pll_rst_d = 1'b0;
                    state_d   = DONE;
                end
            end
            WR: state_d = WR_WAIT;
            WR_WAIT: begin
                if (drp_drdy) begin
                    if (reg_idx_q == LAST_REG) begin
                        pll_rst_d = 1'b0;
                        state_d   = LOCK_WAIT;
                    end else begin
                        reg_idx_d = reg_idx_q + 4'd1;
                        state_d   = RD;
                    end
                end else if (timer_q == DRDY_LIMIT) begin
                    err_d     = 2'd2;
                    pll_rst_d = 1'b0;
                    state_d   = DONE;
                end
            end
            LOCK_WAIT: begin
                if (lock_sync) begin
                    err_d   = 2'd0;
                    state_d = DONE;
                end else if (timer_q == LOCK_LIMIT) begin
                    err_d   = 2'd3;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Timers restart on every state change, so each wait begins at zero.
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == RD_WAIT || state_q == WR_WAIT || state_q == LOCK_WAIT)
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mult_q    <= '0;
            divclk_q  <= '0;
            div_q     <= '0;
            reg_idx_q <= '0;
            rd_data_q <= '0;
            timer_q   <= '0;
            pll_rst_q <= 1'b0;
            err_q     <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            mult_q    <= mult_d;
            divclk_q  <= divclk_d;
            div_q     <= div_d;
            reg_idx_q <= reg_idx_d;
            rd_data_q <= rd_data_d;
            timer_q   <= timer_d;
            pll_rst_q <= pll_rst_d;
            err_q     <= err_d;
        end
    end

    // Two-flop synchroniser for the asynchronous LOCKED pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign pll_rst   = pll_rst_q;
    assign locked    = lock_sync && (state_q == IDLE);
    assign drp_den   = (state_q == RD) || (state_q == WR);
    assign drp_dwe   = (state_q == WR);
    assign drp_daddr = drp_den ? cur_addr : 7'h00;
    assign drp_di    = drp_dwe ? encode_word(cur_addr, cur_val, rd_data_q) : 16'h0000;

endmodule

// File: tb/tb_pll_reconfig.sv
// -----------------------------------------------------------------------------
// tb_pll_reconfig
//   Self-checking bench for pll_reconfig (NUM_OUT=1, short timeouts). It
//   includes a behavioural DRP register file with programmable drdy latency, a
//   PLL lock model and an arithmetic reference for the expected DRP writes.
// -----------------------------------------------------------------------------
module tb_pll_reconfig;

    localparam int NUM_OUT = 1;
    localparam int DRDY_TO = 12;
    localparam int LOCK_TO = 200;
    localparam int NUM_REG = 2 * NUM_OUT + 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_mult;
    logic [5:0]  cfg_divclk;
    logic [6:0]  cfg_clkout_div;
    logic        busy, done;
    logic [1:0]  err;
    logic        pll_rst, drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_drdy = 1'b0;
    logic        pll_locked = 1'b0;
    logic        locked;

    always #5 clk = ~clk;

    pll_reconfig #(
        .NUM_OUT(NUM_OUT), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mult(cfg_mult), .cfg_divclk(cfg_divclk), .cfg_clkout_div(cfg_clkout_div),
        .busy(busy), .done(done), .err(err), .pll_rst(pll_rst),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
        .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .pll_locked(pll_locked), .locked(locked)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- DRP register file model ----------------
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] mem [128];
    wr_t         wlog[$];
    int          lat    = 0;
    bit          drp_on = 1'b1;
    int          pend   = -1;

    always @(negedge clk) begin
        drp_drdy = 1'b0;
        if (pend == 0) begin
            drp_drdy = 1'b1;
            pend     = -1;
        end else if (pend > 0) begin
            pend--;
        end
        if (drp_den && drp_on) begin
            if (drp_dwe) begin
                mem[drp_daddr] = drp_di;
                wlog.push_back('{drp_daddr, drp_di});
            end else begin
                drp_do = mem[drp_daddr];
            end
            pend = lat;
        end
    end

    // ---------------- PLL lock model ----------------
    int lock_delay = 20;
    bit lock_en    = 1'b1;
    int lock_cnt   = 0;

    always @(negedge clk) begin
        if (pll_rst || !lock_en) begin
            pll_locked = 1'b0;
            lock_cnt   = 0;
        end else if (lock_cnt >= lock_delay) begin
            pll_locked = 1'b1;
        end else begin
            lock_cnt++;
        end
    end

    // ---------------- monitors ----------------
    bit den_seen = 1'b0;
    bit rst_seen = 1'b0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (drp_den) den_seen = 1'b1;
        if (pll_rst) rst_seen = 1'b1;
        if (done)    done_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] exp_word(input int addr, input int dval, input logic [15:0] old);
        int hi, lo, ed, nc, o;
        hi = dval / 2;
        lo = dval - hi;
        ed = dval % 2;
        nc = 0;
        if (dval == 1) begin
            hi = 1; lo = 1; ed = 0; nc = 1;
        end
        o = int'(old);
        if (addr == 22) return 16'((o & 'hC000) + ed * 8192 + nc * 4096 + hi * 64 + lo);
        if (addr % 2 == 0) return 16'((o & 'hF000) + hi * 64 + lo);
        return 16'((o & 'hFF3F) + ed * 128 + nc * 64);
    endfunction

    function automatic logic [1:0] exp_check(input int m, input int dc, input int d0);
        if (m < 2 || m > 64 || dc < 1 || dc > 56 || d0 < 1 || d0 > 126) return 2'd1;
        return 2'd0;
    endfunction

    // ---------------- request driver ----------------
    task automatic run_req(input logic [6:0] m, input logic [5:0] dc, input logic [6:0] d0,
                           input int pulse_at, input string name,
                           output int cyc, output bit got, output logic [1:0] e);
        @(negedge clk);
        check({name, "_ready"}, cfg_ready, 1);
        cfg_mult       = m;
        cfg_divclk     = dc;
        cfg_clkout_div = d0;
        cfg_valid      = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        e   = 2'bxx;
        while (!got && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            cfg_valid = (cyc == pulse_at);
            if (cyc == pulse_at) cfg_mult = 7'd10;
            if (done) begin
                got = 1'b1;
                e   = err;
            end
        end
        cfg_valid = 1'b0;
    endtask

    function automatic logic [31:0] log_data(input int i);
        if (i < wlog.size()) return 32'(wlog[i].data);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_addr(input int i);
        if (i < wlog.size()) return 32'(wlog[i].addr);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_case(input string name, input logic [6:0] m, input logic [5:0] dc,
                           input logic [6:0] d0, input bit rand_fill, input logic [15:0] fill,
                           input int lat_i, input logic [1:0] exp_err, input int pulse_at);
        int          ea[$];
        int          ev[$];
        logic [15:0] ew[$];
        int          cyc;
        bit          got;
        logic [1:0]  e;
        ea.push_back(8);  ev.push_back(int'(d0));
        ea.push_back(9);  ev.push_back(int'(d0));
        ea.push_back(20); ev.push_back(int'(m));
        ea.push_back(21); ev.push_back(int'(m));
        ea.push_back(22); ev.push_back(int'(dc));
        for (int i = 0; i < ea.size(); i++) begin
            mem[ea[i]] = rand_fill ? 16'($urandom) : fill;
            ew.push_back(exp_word(ea[i], ev[i], mem[ea[i]]));
        end
        wlog.delete();
        lat      = lat_i;
        den_seen = 1'b0;
        rst_seen = 1'b0;
        run_req(m, dc, d0, pulse_at, name, cyc, got, e);
        check({name, "_done"}, got, 1);
        check({name, "_err"}, e, exp_err);
        if (exp_err == 2'd1) begin
            check({name, "_latency"}, cyc, 2);
            check({name, "_no_den"}, den_seen, 0);
            check({name, "_no_pllrst"}, rst_seen, 0);
        end else begin
            check({name, "_nwrites"}, wlog.size(), NUM_REG);
            for (int i = 0; i < ea.size(); i++) begin
                check($sformatf("%s_waddr%0d", name, i), log_addr(i), ea[i]);
                check($sformatf("%s_wdata%0d", name, i), log_data(i), ew[i]);
            end
            check({name, "_pllrst_low"}, pll_rst, 0);
            if (exp_err == 2'd3 && lat_i == 0)
                check({name, "_lock_latency"}, cyc, 3 + 4 * NUM_REG + LOCK_TO);
            @(negedge clk);
            check({name, "_ready_after"}, cfg_ready, 1);
            check({name, "_locked_after"}, locked, (exp_err == 2'd0) ? 1 : 0);
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] m;
        logic [5:0] dc;
        logic [6:0] d0;
        logic [15:0] fill;
        int         lat;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          cyc;
        bit          got;
        logic [1:0]  e;
        int          dc_before;
        logic [6:0]  rm, rd0;
        logic [5:0]  rdc;

        vecs[0] = '{"v_min",      7'd2,   6'd1,  7'd1,   16'h1234, 0, 2'd0};
        vecs[1] = '{"v_max",      7'd64,  6'd56, 7'd126, 16'hA5A5, 1, 2'd0};
        vecs[2] = '{"v_mid_lat",  7'd17,  6'd3,  7'd6,   16'h5AF0, 3, 2'd0};
        vecs[3] = '{"bad_div0",   7'd34,  6'd5,  7'd0,   16'hFFFF, 0, 2'd1};
        vecs[4] = '{"bad_mult65", 7'd65,  6'd5,  7'd17,  16'hFFFF, 0, 2'd1};
        vecs[5] = '{"bad_mult1",  7'd1,   6'd5,  7'd17,  16'hFFFF, 0, 2'd1};
        vecs[6] = '{"bad_dc0",    7'd34,  6'd0,  7'd17,  16'hFFFF, 0, 2'd1};
        vecs[7] = '{"bad_dc57",   7'd34,  6'd57, 7'd17,  16'hFFFF, 0, 2'd1};
        vecs[8] = '{"bad_div127", 7'd34,  6'd5,  7'd127, 16'hFFFF, 0, 2'd1};
        vecs[9] = '{"v_odd",      7'd63,  6'd55, 7'd125, 16'h0F0F, 2, 2'd0};

        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        rst_n          = 1'b0;
        cfg_valid      = 1'b0;
        cfg_mult       = '0;
        cfg_divclk     = '0;
        cfg_clkout_div = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",   cfg_ready, 1);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_err",     err, 0);
        check("rst_pllrst",  pll_rst, 0);
        check("rst_den",     drp_den, 0);
        check("rst_dwe",     drp_dwe, 0);
        check("rst_daddr",   drp_daddr, 0);
        check("rst_di",      drp_di, 0);
        check("rst_locked",  locked, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Worked example: all-ones read-back
        lock_delay = 100;
        do_case("spec_ex", 7'd34, 6'd5, 7'd17, 1'b0, 16'hFFFF, 0, 2'd0, -1);
        check("spec_ex_0x08", log_data(0), 32'hF209);
        check("spec_ex_0x09", log_data(1), 32'hFFBF);
        check("spec_ex_0x14", log_data(2), 32'hF451);
        check("spec_ex_0x15", log_data(3), 32'hFF3F);
        check("spec_ex_0x16", log_data(4), 32'hE083);

        // Divide-by-one bypass with all-zero read-back
        lock_delay = 20;
        do_case("div1", 7'd34, 6'd5, 7'd1, 1'b0, 16'h0000, 0, 2'd0, -1);
        check("div1_0x08", log_data(0), 32'h0041);
        check("div1_0x09", log_data(1), 32'h0040);

        // Table of legal / illegal configurations
        for (int i = 0; i < 10; i++)
            do_case(vecs[i].name, vecs[i].m, vecs[i].dc, vecs[i].d0, 1'b0, vecs[i].fill,
                    vecs[i].lat, vecs[i].exp_err, -1);

        // DRP never answers
        drp_on = 1'b0;
        wlog.delete();
        run_req(7'd34, 6'd5, 7'd17, -1, "drdy_to", cyc, got, e);
        check("drdy_to_done", got, 1);
        check("drdy_to_err", e, 2);
        check("drdy_to_latency", cyc, DRDY_TO + 4);
        check("drdy_to_pllrst", pll_rst, 0);
        check("drdy_to_nwrites", wlog.size(), 0);
        @(negedge clk);
        check("drdy_to_idle", cfg_ready, 1);
        drp_on = 1'b1;
        repeat (4) @(negedge clk);

        // Lock never arrives; a request pulsed while busy must be ignored
        lock_en   = 1'b0;
        dc_before = done_cnt;
        do_case("lock_to", 7'd34, 6'd5, 7'd17, 1'b1, 16'h0000, 0, 2'd3, 30);
        check("lock_to_single_done", done_cnt - dc_before, 1);
        check("lock_to_not_busy", busy, 0);
        lock_en = 1'b1;

        // Reset in the middle of WR_WAIT
        lat = 6;
        @(negedge clk);
        cfg_mult = 7'd34; cfg_divclk = 6'd5; cfg_clkout_div = 7'd17; cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (drp_den && drp_dwe) got = 1'b1;
        end
        check("rstmid_reached_wr", got, 1);
        @(negedge clk);
        dc_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rstmid_den", drp_den, 0);
        check("rstmid_pllrst", pll_rst, 0);
        check("rstmid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready", cfg_ready, 1);
        repeat (30) @(negedge clk);
        check("rstmid_no_done", done_cnt - dc_before, 0);
        check("rstmid_still_idle", busy, 0);

        // Randomised requests against the reference model
        for (int t = 0; t < 30; t++) begin
            rm  = 7'($urandom_range(0, 70));
            rdc = 6'($urandom_range(0, 60));
            rd0 = 7'($urandom_range(0, 127));
            do_case($sformatf("rnd%0d", t), rm, rdc, rd0, 1'b1, 16'h0000,
                    int'($urandom_range(0, 3)), exp_check(int'(rm), int'(rdc), int'(rd0)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
